sram_cmd_fsm: RTL and testbench
===============================

// Module: sram_cmd_fsm
// PURPOSE
//  Parametrised command controller for one single-port SRAM macro in the Onyx SRAM subsystem.
//  Accepts power/read/write commands over a valid/ready channel, with a separate write-data channel.
//  Sequences the SRAM pins and returns read data on a valid/ready response channel.
//  Replaces fixed-width, handshake-less control with a timed wake-up and illegal-command reporting.
// PARAMETERS
//  DATA_W      16  SRAM word / client data width
//  ADDR_W      9   SRAM word address width
//  CMD_W       4   opcode width (>=3)
//  WAKE_CYCLES 4   cycles from POWER_ON accept to ON; must be >=1
//  ERR_CNT_W   8   illegal-command counter width (used only with SRAM_FSM_ERR_COUNT_EN)
// PORTS
//  CLK          in   1       clock, rising edge
//  ASYNCRESET   in   1       reset, asynchronous, active-high
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when valid&ready
//  cmd_op       in   CMD_W   opcode
//  cmd_addr     in   ADDR_W  word address (READ/WRITE)
//  wdata_valid  in   1       write data offered
//  wdata_ready  out  1       write data accepted when valid&ready
//  wdata        in   DATA_W  write data
//  rdata_valid  out  1       read response valid
//  rdata_ready  in   1       read response consumed when valid&ready
//  rdata        out  DATA_W  read response data
//  mem_pwr      out  1       SRAM power enable
//  mem_cen      out  1       SRAM chip enable, active-high
//  mem_wen      out  1       SRAM write enable, active-high
//  mem_addr     out  ADDR_W  SRAM address
//  mem_wdata    out  DATA_W  SRAM write data
//  mem_rdata    in   DATA_W  SRAM read data, valid the cycle after mem_cen&!mem_wen
//  err_pulse    out  1       one-cycle pulse on an illegal or out-of-state command
//  cur_state    out  3       current FSM state encoding
// BEHAVIOUR
//  Opcodes: 0 NOP, 1 POWER_ON, 2 POWER_OFF, 3 READ, 4 WRITE; every other value is illegal.
//  States: OFF=0, WAKE=1, ON=2, RD_ISSUE=3, RD_CAPT=4, RD_RESP=5, WR_DATA=6.
//  Reset state: OFF. Every registered output resets to 0: rdata, rdata_valid, mem_*, err_pulse.
//  Reset mid-operation immediately drops mem_pwr, mem_cen and rdata_valid; the transaction is lost.
//  cmd_ready = state is OFF or ON (combinational from state). wdata_ready = state is WR_DATA.
//  OFF: POWER_ON -> WAKE, mem_pwr<=1, wake counter<=WAKE_CYCLES-1. NOP -> no effect.
//   Any other opcode is consumed: err_pulse, state stays OFF.
//  WAKE: counter decrements each cycle; at 0 -> ON. Exactly WAKE_CYCLES cycles in WAKE.
//  ON: NOP and POWER_ON -> no effect. POWER_OFF -> OFF, mem_pwr<=0.
//   READ -> RD_ISSUE with mem_cen<=1, mem_wen<=0, mem_addr<=cmd_addr.
//   WRITE -> WR_DATA, address latched into mem_addr. Illegal opcode -> err_pulse, stay ON.
//  RD_ISSUE -> RD_CAPT, mem_cen<=0.
//  RD_CAPT: rdata<=mem_rdata, rdata_valid<=1 -> RD_RESP.
//   rdata_valid rises 2 cycles after the cmd accept edge.
//  RD_RESP: hold rdata/rdata_valid stable until rdata_ready; then rdata_valid<=0 -> ON.
//   If rdata_ready is already high, one-cycle response.
//  WR_DATA: wait indefinitely for wdata_valid. On accept: mem_cen<=1, mem_wen<=1, mem_wdata<=wdata,
//   for one cycle, -> ON. A command may be accepted the cycle the write strobe is high.
//  mem_cen is never high for 2 consecutive cycles. The response channel holds one entry (no buffering).
//  err_pulse is high exactly one cycle per offending accepted command.
// CONFIGURATION
//  SRAM_FSM_ERR_COUNT_EN defined: adds output port err_count [ERR_CNT_W-1:0], reset 0.
//   Increments with each err_pulse and saturates at all-ones; cleared only by ASYNCRESET.
//  Not defined: port and counter absent; err_pulse behaviour unchanged.
// STRUCTURE
//  Package onyx_sram_pkg: opcode enum sram_op_e, state enum sram_state_e (3 bits).
//  Package localparams OP_NOP..OP_WRITE.
//  Sub-module sram_wake_timer: loadable down-counter with done flag, parametrised width $clog2(WAKE_CYCLES+1).
//  Everything else lives in one always_ff next-state/output block.
// TESTING
//  1 Reset, then POWER_ON at cycle 0 with WAKE_CYCLES=4 -> mem_pwr=1 next edge; cur_state=1 for 4 cycles, then 2.
//  2 ON, WRITE addr 0x05 then wdata 0xBEEF -> one cycle mem_cen=1, mem_wen=1, mem_addr=0x05, mem_wdata=0xBEEF.
//  3 ON, READ 0x05 with model returning 0xBEEF, rdata_ready=0 for 3 cycles
//     -> rdata_valid=1, rdata=0xBEEF 2 cycles after accept, stable until ready; cmd_ready=0 meanwhile.
//  4 OFF, READ, then opcode 7 -> err_pulse twice, state stays 0; with SRAM_FSM_ERR_COUNT_EN, err_count=2.
//     ERR_CNT_W=2 and 5 errors -> err_count saturates at 3.
//  5 ASYNCRESET asserted mid-RD_RESP (no clock edge) -> rdata_valid, mem_pwr=0 immediately, cur_state=0.
//  6 ON, POWER_OFF -> mem_pwr=0, cur_state=0; following POWER_ON repeats the full WAKE_CYCLES wait.

Source files
------------

// File: rtl/onyx_sram_pkg.sv
// Shared opcode and state definitions for the Onyx SRAM command controller.
package onyx_sram_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_POWER_ON  = 3'd1;
  localparam logic [2:0] OP_POWER_OFF = 3'd2;
  localparam logic [2:0] OP_READ      = 3'd3;
  localparam logic [2:0] OP_WRITE     = 3'd4;

  typedef enum logic [2:0] {
    SOP_NOP       = OP_NOP,
    SOP_POWER_ON  = OP_POWER_ON,
    SOP_POWER_OFF = OP_POWER_OFF,
    SOP_READ      = OP_READ,
    SOP_WRITE     = OP_WRITE
  } sram_op_e;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAKE     = 3'd1,
    ST_ON       = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_CAPT  = 3'd4,
    ST_RD_RESP  = 3'd5,
    ST_WR_DATA  = 3'd6
  } sram_state_e;

endpackage

// File: rtl/sram_wake_timer.sv
// Loadable down-counter timing the SRAM power-up interval; done while the count is zero.
module sram_wake_timer #(
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic CLK,
  input  logic ASYNCRESET,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(WAKE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(WAKE_CYCLES - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sram_cmd_fsm.sv
// Command controller for one single-port SRAM macro: power sequencing, reads, writes.
// Optional SRAM_FSM_ERR_COUNT_EN adds a saturating illegal-command counter output.
module sram_cmd_fsm
  import onyx_sram_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned CMD_W       = 4,
  parameter int unsigned WAKE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              ASYNCRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_pwr,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_pulse,
`ifdef SRAM_FSM_ERR_COUNT_EN
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  output logic [2:0]        cur_state
);

  if (WAKE_CYCLES < 1 || CMD_W < 3 || ERR_CNT_W < 1) begin : g_bad_cfg
    $error("sram_cmd_fsm: invalid parameter set");
  end

  sram_state_e state_q, state_d;
  logic              pwr_d, cen_d, wen_d, rvalid_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;
  logic              op_legal, wake_load, wake_dec, wake_done;
  sram_op_e          op;

  assign op_legal    = (cmd_op <= CMD_W'(OP_WRITE));
  assign op          = sram_op_e'(cmd_op[2:0]);
  assign cmd_ready   = (state_q == ST_OFF) || (state_q == ST_ON);
  assign wdata_ready = (state_q == ST_WR_DATA);
  assign cur_state   = state_q;
  assign wake_load   = (state_q == ST_OFF) && (state_d == ST_WAKE);
  assign wake_dec    = (state_q == ST_WAKE);

  sram_wake_timer #(.WAKE_CYCLES(WAKE_CYCLES)) u_wake_timer (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .load       (wake_load),
    .dec        (wake_dec),
    .done       (wake_done)
  );

  always_comb begin
    state_d  = state_q;
    pwr_d    = mem_pwr;
    cen_d    = 1'b0;
    wen_d    = 1'b0;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    rdata_d  = rdata;
    rvalid_d = rdata_valid;
    err_d    = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (cmd_valid) begin
          if (op_legal && op == SOP_POWER_ON) begin
            state_d = ST_WAKE;
            pwr_d   = 1'b1;
          end else if (!(op_legal && op == SOP_NOP)) begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAKE: if (wake_done) state_d = ST_ON;
      ST_ON: begin
        if (cmd_valid) begin
          if (!op_legal) begin
            err_d = 1'b1;
          end else begin
            unique case (op)
              SOP_POWER_OFF: begin
                state_d = ST_OFF;
                pwr_d   = 1'b0;
              end
              // A read accepted during a write strobe defers its own strobe by one cycle
              SOP_READ: begin
                state_d = ST_RD_ISSUE;
                cen_d   = !mem_cen;
                addr_d  = cmd_addr;
              end
              SOP_WRITE: begin
                state_d = ST_WR_DATA;
                addr_d  = cmd_addr;
              end
              default: ;
            endcase
          end
        end
      end
      ST_RD_ISSUE: begin
        if (mem_cen) state_d = ST_RD_CAPT;
        else         cen_d   = 1'b1;
      end
      ST_RD_CAPT: begin
        rdata_d  = mem_rdata;
        rvalid_d = 1'b1;
        state_d  = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (rdata_ready) begin
          rvalid_d = 1'b0;
          state_d  = ST_ON;
        end
      end
      ST_WR_DATA: begin
        if (wdata_valid) begin
          cen_d   = 1'b1;
          wen_d   = 1'b1;
          wdata_d = wdata;
          state_d = ST_ON;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q     <= ST_OFF;
      mem_pwr     <= 1'b0;
      mem_cen     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_pwr     <= pwr_d;
      mem_cen     <= cen_d;
      mem_wen     <= wen_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      rdata       <= rdata_d;
      rdata_valid <= rvalid_d;
      err_pulse   <= err_d;
    end
  end

`ifdef SRAM_FSM_ERR_COUNT_EN
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      err_count <= '0;
    end else if (err_d && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_cmd_fsm.sv
// Bench for sram_cmd_fsm: directed scenarios plus randomized traffic against a behavioural model.
module tb_sram_cmd_fsm;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int CW = 4;
  localparam int WC = 4;
  localparam int EW = 2;

  logic          CLK = 1'b0;
  logic          ASYNCRESET = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [CW-1:0] cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic          wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          rdata_valid, rdata_ready = 1'b0;
  logic [DW-1:0] rdata;
  logic          mem_pwr, mem_cen, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;
  logic          err_pulse;
  logic [2:0]    cur_state;
`ifdef SRAM_FSM_ERR_COUNT_EN
  logic [EW-1:0] err_count;
`endif

  always #5 CLK = ~CLK;

  sram_cmd_fsm #(.DATA_W(DW), .ADDR_W(AW), .CMD_W(CW), .WAKE_CYCLES(WC), .ERR_CNT_W(EW)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .mem_pwr(mem_pwr), .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_pulse(err_pulse),
`ifdef SRAM_FSM_ERR_COUNT_EN
    .err_count(err_count),
`endif
    .cur_state(cur_state)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  // SRAM macro: read data appears the cycle after a read strobe
  logic [DW-1:0] bmem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1<<AW); i++) bmem[i] = init_word(i);
    forever begin
      @(posedge CLK);
      if (mem_cen && !mem_wen) mem_rdata <= bmem[mem_addr];
      if (mem_cen && mem_wen) bmem[mem_addr] = mem_wdata;
    end
  end

  // Behavioural model: what the controller is doing, described by transaction progress
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            m_pwr, m_rvalid, m_wr_wait, m_cen, m_wen, m_err;
  int            m_wake, m_rd_t, m_rd_d, m_errcnt;
  logic [AW-1:0] m_addr, m_rd_addr;
  logic [DW-1:0] m_rdata, m_wdata;

  initial begin
    bit pc;
    for (int i = 0; i < (1<<AW); i++) shadow[i] = init_word(i);
    forever begin
      @(posedge CLK or posedge ASYNCRESET);
      if (ASYNCRESET) begin
        m_pwr = 0; m_rvalid = 0; m_wr_wait = 0; m_cen = 0; m_wen = 0; m_err = 0;
        m_wake = 0; m_rd_t = 0; m_rd_d = 0; m_errcnt = 0;
        m_addr = '0; m_rd_addr = '0; m_rdata = '0; m_wdata = '0;
      end else begin
        pc = m_cen;
        m_cen = 0; m_wen = 0; m_err = 0;
        if (!m_pwr) begin
          if (cmd_valid) begin
            if (cmd_op == 1) begin m_pwr = 1; m_wake = WC; end
            else if (cmd_op != 0) m_err = 1;
          end
        end else if (m_wake > 0) begin
          m_wake--;
        end else if (m_rd_t > 0) begin
          if (m_rd_t == m_rd_d) m_cen = 1;
          if (m_rd_t == 2 + m_rd_d) begin
            m_rvalid = 1; m_rdata = shadow[m_rd_addr]; m_rd_t = 0;
          end else m_rd_t++;
        end else if (m_rvalid) begin
          if (rdata_ready) m_rvalid = 0;
        end else if (m_wr_wait) begin
          if (wdata_valid) begin
            m_cen = 1; m_wen = 1; m_wdata = wdata; shadow[m_addr] = wdata; m_wr_wait = 0;
          end
        end else if (cmd_valid) begin
          case (cmd_op)
            0, 1: ;
            2: m_pwr = 0;
            3: begin
              m_rd_t = 1; m_rd_d = pc ? 1 : 0; m_cen = !pc; m_addr = cmd_addr; m_rd_addr = cmd_addr;
            end
            4: begin m_wr_wait = 1; m_addr = cmd_addr; end
            default: m_err = 1;
          endcase
        end
        if (m_err && m_errcnt < (1<<EW) - 1) m_errcnt++;
      end
    end
  end

  function automatic int exp_state();
    if (!m_pwr) return 0;
    if (m_wake > 0) return 1;
    if (m_rd_t > 0) return (m_rd_t <= 1 + m_rd_d) ? 3 : 4;
    if (m_rvalid) return 5;
    if (m_wr_wait) return 6;
    return 2;
  endfunction

  always @(posedge CLK) begin
    #1;
    chk("m_state", cur_state, exp_state());
    chk("m_cmd_ready", cmd_ready, (exp_state() == 0 || exp_state() == 2));
    chk("m_wdata_ready", wdata_ready, (exp_state() == 6));
    chk("m_pwr", mem_pwr, m_pwr);
    chk("m_cen", mem_cen, m_cen);
    chk("m_wen", mem_wen, m_wen);
    chk("m_addr", mem_addr, m_addr);
    chk("m_wdata", mem_wdata, m_wdata);
    chk("m_rvalid", rdata_valid, m_rvalid);
    chk("m_rdata", rdata, m_rdata);
    chk("m_err", err_pulse, m_err);
`ifdef SRAM_FSM_ERR_COUNT_EN
    chk("m_errcnt", err_count, m_errcnt);
`endif
  end

  task automatic power_on_wait(input string tag);
    @(negedge CLK); cmd_valid = 1; cmd_op = 1;
    @(posedge CLK); #1;
    chk({tag, "_pwr"}, mem_pwr, 1);
    chk({tag, "_wake0"}, cur_state, 1);
    @(negedge CLK); cmd_valid = 0;
    for (int i = 0; i < WC - 1; i++) begin
      @(posedge CLK); #1; chk({tag, "_wake"}, cur_state, 1);
    end
    @(posedge CLK); #1; chk({tag, "_on"}, cur_state, 2);
  endtask

  initial begin
    int r;
    repeat (3) @(negedge CLK);
    ASYNCRESET = 0;
    @(posedge CLK); #1;
    chk("rst_state", cur_state, 0);
    chk("rst_pwr", mem_pwr, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    power_on_wait("t1");

    @(negedge CLK); cmd_valid = 1; cmd_op = 4; cmd_addr = 9'h005;
    @(posedge CLK); #1;
    chk("t2_state", cur_state, 6); chk("t2_wready", wdata_ready, 1); chk("t2_cready", cmd_ready, 0);
    @(negedge CLK); cmd_valid = 0; wdata_valid = 1; wdata = 16'hBEEF;
    @(posedge CLK); #1;
    chk("t2_cen", mem_cen, 1); chk("t2_wen", mem_wen, 1);
    chk("t2_addr", mem_addr, 9'h005); chk("t2_wdata", mem_wdata, 16'hBEEF);
    @(negedge CLK); wdata_valid = 0;
    @(posedge CLK); #1; chk("t2_cen_drop", mem_cen, 0);

    @(negedge CLK); cmd_valid = 1; cmd_op = 3; cmd_addr = 9'h005; rdata_ready = 0;
    @(posedge CLK); #1; chk("t3_issue", cur_state, 3); chk("t3_cen", mem_cen, 1);
    @(negedge CLK); cmd_valid = 0;
    @(posedge CLK); #1; chk("t3_capt_rvalid", rdata_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("t3_rvalid", rdata_valid, 1); chk("t3_rdata", rdata, 16'hBEEF); chk("t3_cready", cmd_ready, 0);
    end
    @(negedge CLK); rdata_ready = 1;
    @(posedge CLK); #1; chk("t3_consumed", rdata_valid, 0); chk("t3_on", cur_state, 2);
    @(negedge CLK); rdata_ready = 0;

    @(negedge CLK); cmd_valid = 1; cmd_op = 2;
    @(posedge CLK); #1; chk("t6_off_pwr", mem_pwr, 0); chk("t6_off_state", cur_state, 0);
    @(negedge CLK); cmd_op = 3;
    @(posedge CLK); #1; chk("t4_err_read", err_pulse, 1); chk("t4_state", cur_state, 0);
    @(negedge CLK); cmd_op = 7;
    @(posedge CLK); #1; chk("t4_err_op7", err_pulse, 1);
    @(negedge CLK); cmd_valid = 0;
    @(posedge CLK); #1; chk("t4_err_clear", err_pulse, 0);
`ifdef SRAM_FSM_ERR_COUNT_EN
    chk("t4_errcnt2", err_count, 2);
`endif
    @(negedge CLK); cmd_valid = 1; cmd_op = 15;
    repeat (3) @(posedge CLK);
    @(negedge CLK); cmd_valid = 0;
    @(posedge CLK); #1;
`ifdef SRAM_FSM_ERR_COUNT_EN
    chk("t4_errcnt_sat", err_count, 3);
`endif

    power_on_wait("t6");

    @(negedge CLK); cmd_valid = 1; cmd_op = 3; cmd_addr = 9'h005; rdata_ready = 0;
    @(negedge CLK); cmd_valid = 0;
    for (int i = 0; i < 8 && !rdata_valid; i++) begin @(posedge CLK); #1; end
    chk("t5_reach_resp", rdata_valid, 1);
    #2 ASYNCRESET = 1;
    #1;
    chk("t5_rvalid", rdata_valid, 0); chk("t5_pwr", mem_pwr, 0); chk("t5_state", cur_state, 0);
    @(negedge CLK); ASYNCRESET = 0;

    repeat (4000) begin
      @(negedge CLK);
      cmd_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      cmd_op = (r < 8) ? 4'd2 : (r < 30) ? 4'd3 : (r < 50) ? 4'd4 : (r < 65) ? 4'd1 :
               (r < 80) ? 4'd0 : 4'($urandom_range(5, 15));
      cmd_addr = 9'($urandom_range(0, 15));
      wdata_valid = ($urandom_range(0, 2) == 0);
      wdata = 16'($urandom);
      rdata_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 ASYNCRESET = 1;
        @(negedge CLK); ASYNCRESET = 0;
      end
    end
    @(negedge CLK); cmd_valid = 0; wdata_valid = 0;
    repeat (2) @(posedge CLK);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
